// File: rtl/game_fsm_ctrl_pkg.sv
// game_fsm_ctrl_pkg: shared state encoding and parameter defaults for the game controller
package game_fsm_ctrl_pkg;
  typedef enum logic [2:0] {
    NEWGAME = 3'd0,
    PLAY    = 3'd1,
    NEWBALL = 3'd2,
    PAUSE   = 3'd3,
    OVER    = 3'd4
  } state_t;
  localparam int LIVES_DEF       = 3;
  localparam int DIGITS_DEF      = 2;
  localparam int WAIT_FRAMES_DEF = 120;
  localparam int TIMER_W         = 10;
endpackage

// File: rtl/game_fsm_ctrl_bcd_counter.sv
// bcd_counter: saturating multi-digit BCD up-counter with synchronous clear
module bcd_counter #(
  parameter int DIGITS = game_fsm_ctrl_pkg::DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   count_nxt
);
  logic [4*DIGITS-1:0] count_q, count_d;
  logic sat, c;
  always_comb begin
    sat = 1'b1;
    for (int i = 0; i < DIGITS; i++) sat = sat & (count_q[4*i+:4] == 4'd9);
    count_d = count_q;
    c = inc & ~sat;
    for (int i = 0; i < DIGITS; i++) begin
      count_d[4*i+:4] = c ? ((count_q[4*i+:4] == 4'd9) ? 4'd0 : count_q[4*i+:4] + 4'd1) : count_q[4*i+:4];
      c = c & (count_q[4*i+:4] == 4'd9);
    end
    if (clr) count_d = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
  assign count_nxt = count_d;
endmodule

// File: rtl/game_fsm_ctrl.sv
// game_fsm_ctrl: pong-style game flow FSM with lives, BCD score, hiscore and frame wait timer
module game_fsm_ctrl
  import game_fsm_ctrl_pkg::*;
#(
  parameter int LIVES       = LIVES_DEF,
  parameter int DIGITS      = DIGITS_DEF,
  parameter int WAIT_FRAMES = WAIT_FRAMES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [1:0]          btn,
  input  logic                pause_btn,
  input  logic                hit,
  input  logic                miss,
  output logic                gra_still,
  output logic [2:0]          state,
  output logic [3:0]          lives,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] hiscore
);
  state_t state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [4*DIGITS-1:0] hiscore_q, hiscore_d, score_nxt;
  logic pause_q, pause_rise, score_inc;
  assign pause_rise = pause_btn & ~pause_q;
  assign score_inc = (state_q == PLAY) & hit;
  bcd_counter #(.DIGITS(DIGITS)) u_score (
    .clk(clk),
    .reset(reset),
    .clr(state_q == NEWGAME),
    .inc(score_inc),
    .count(score),
    .count_nxt(score_nxt)
  );
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    hiscore_d = hiscore_q;
    timer_d = (frame_tick && timer_q != '0) ? timer_q - 1'b1 : timer_q;
    case (state_q)
      NEWGAME: begin
        lives_d = 4'(LIVES);
        state_d = (btn != 2'b00) ? PLAY : NEWGAME;
      end
      PLAY: begin
        if (miss) begin
          lives_d = lives_q - 4'd1;
          timer_d = TIMER_W'(WAIT_FRAMES);
          state_d = (lives_q == 4'd1) ? OVER : NEWBALL;
          hiscore_d = (lives_q == 4'd1 && score_nxt > hiscore_q) ? score_nxt : hiscore_q;
        end else if (pause_rise) begin
          state_d = PAUSE;
        end
      end
      PAUSE:   state_d = pause_rise ? PLAY : PAUSE;
      NEWBALL: state_d = (timer_q == '0 && btn != 2'b00) ? PLAY : NEWBALL;
      OVER:    state_d = (timer_q == '0) ? NEWGAME : OVER;
      default: state_d = NEWGAME;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NEWGAME;
      lives_q <= 4'(LIVES);
      timer_q <= '0;
      hiscore_q <= '0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
      hiscore_q <= hiscore_d;
      pause_q <= pause_btn;
    end
  end
  assign gra_still = (state_q != PLAY);
  assign state = state_q;
  assign lives = lives_q;
  assign hiscore = hiscore_q;
endmodule

// File: tb/tb_game_fsm_ctrl.sv
// tb_game_fsm_ctrl: directed self-checking bench for game_fsm_ctrl with default parameters
module tb_game_fsm_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic pause_btn = 1'b0;
  logic hit = 1'b0;
  logic miss = 1'b0;
  logic gra_still;
  logic [2:0] state;
  logic [3:0] lives;
  logic [7:0] score, hiscore;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  game_fsm_ctrl dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .btn(btn),
    .pause_btn(pause_btn),
    .hit(hit),
    .miss(miss),
    .gra_still(gra_still),
    .state(state),
    .lives(lives),
    .score(score),
    .hiscore(hiscore)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask
  task automatic pulse_hit();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
  endtask
  task automatic wait_out(input string tag, input logic [2:0] st_hold, input logic [2:0] st_exit);
    for (int i = 0; i < 119; i++) tick();
    chk({tag, "_hold119"}, state, st_hold);
    tick();
    chk({tag, "_exit120"}, state, st_exit);
  endtask
  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 8'h00);
    chk("rst_hiscore", hiscore, 8'h00);
    chk("rst_still", gra_still, 1);
    pause_btn = 1'b1;
    cyc();
    chk("pause_ignored_newgame", state, 0);
    pause_btn = 1'b0;
    btn = 2'b01;
    cyc();
    btn = 2'b00;
    chk("start_state", state, 1);
    chk("start_still", gra_still, 0);
    for (int i = 0; i < 5; i++) pulse_hit();
    cyc();
    chk("hits5_score", score, 8'h05);
    chk("hits5_lives", lives, 3);
    pause_btn = 1'b1;
    cyc();
    chk("pause_enter", state, 3);
    chk("pause_still", gra_still, 1);
    hit = 1'b1;
    miss = 1'b1;
    btn = 2'b11;
    cyc();
    hit = 1'b0;
    miss = 1'b0;
    btn = 2'b00;
    chk("pause_score", score, 8'h05);
    chk("pause_lives", lives, 3);
    chk("pause_hold", state, 3);
    pause_btn = 1'b0;
    cyc();
    chk("pause_level_low", state, 3);
    pause_btn = 1'b1;
    cyc();
    pause_btn = 1'b0;
    chk("pause_exit", state, 1);
    miss = 1'b1;
    frame_tick = 1'b1;
    cyc();
    miss = 1'b0;
    frame_tick = 1'b0;
    chk("miss1_state", state, 2);
    chk("miss1_lives", lives, 2);
    btn = 2'b01;
    wait_out("ball1", 3'd2, 3'd1);
    btn = 2'b00;
    hit = 1'b1;
    miss = 1'b1;
    cyc();
    hit = 1'b0;
    miss = 1'b0;
    chk("hitmiss_score", score, 8'h06);
    chk("hitmiss_lives", lives, 1);
    chk("hitmiss_state", state, 2);
    btn = 2'b10;
    wait_out("ball2", 3'd2, 3'd1);
    btn = 2'b00;
    for (int i = 0; i < 92; i++) pulse_hit();
    cyc();
    chk("score98", score, 8'h98);
    pulse_hit();
    chk("sat_hit1", score, 8'h99);
    pulse_hit();
    chk("sat_hit2", score, 8'h99);
    pulse_hit();
    chk("sat_hit3", score, 8'h99);
    chk("pre_over_hiscore", hiscore, 8'h00);
    miss = 1'b1;
    cyc();
    miss = 1'b0;
    chk("over_state", state, 4);
    chk("over_lives", lives, 0);
    chk("over_hiscore", hiscore, 8'h99);
    wait_out("over", 3'd4, 3'd0);
    cyc();
    chk("newgame_score_clr", score, 8'h00);
    chk("newgame_lives", lives, 3);
    chk("newgame_hiscore", hiscore, 8'h99);
    btn = 2'b01;
    cyc();
    btn = 2'b00;
    chk("game2_play", state, 1);
    miss = 1'b1;
    cyc();
    miss = 1'b0;
    chk("game2_newball", state, 2);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midball_rst_state", state, 0);
    chk("midball_rst_hiscore", hiscore, 8'h00);
    chk("midball_rst_lives", lives, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_fsm_ctrl.md
GAME_FSM_CTRL -- requirements
Module: game_fsm_ctrl

Interface
REQ-001 Parameter LIVES, default 3: balls per game, range 1..15.
REQ-002 Parameter DIGITS, default 2: BCD score digits, range 1..4.
REQ-003 Parameter WAIT_FRAMES, default 120: inter-ball/game-over wait in frames (2 s at 60 Hz), range 1..1023.
REQ-004 Port clk, in, 1: 100 MHz system clock.
REQ-005 Port reset, in, 1: reset is synchronous and active-high, sampled on the clk rising edge.
REQ-006 Port frame_tick, in, 1: one-cycle pulse at each frame start (x==0, y==0).
REQ-007 Port btn, in, 2: paddle buttons; any nonzero value counts as "start".
REQ-008 Port pause_btn, in, 1: level input; each rising edge is a pause request.
REQ-009 Port hit, in, 1: one-cycle paddle-hit pulse.
REQ-010 Port miss, in, 1: one-cycle ball-lost pulse.
REQ-011 Port gra_still, out, 1: freeze graphics.
REQ-012 Port state, out, 3: current state encoding.
REQ-013 Port lives, out, 4: balls remaining.
REQ-014 Port score, out, 4*DIGITS: BCD score, digit 0 in the LSBs.
REQ-015 Port hiscore, out, 4*DIGITS: BCD best score since reset.

Function
REQ-016 The FSM SHALL have the states NEWGAME=0, PLAY=1, NEWBALL=2, PAUSE=3, OVER=4; all outputs are registered except gra_still.
REQ-017 gra_still SHALL be 0 only in PLAY.
REQ-018 NEWGAME: score is held at 0 and lives at LIVES; btn!=0 moves the FSM to PLAY on the next cycle.
REQ-019 PLAY, hit: score increments by 1 BCD with per-digit carry and saturates at all-9s (no wrap).
REQ-020 PLAY, miss: lives decrements and the timer loads WAIT_FRAMES; the FSM moves to OVER if lives==1, otherwise to NEWBALL.
REQ-021 PLAY, hit and miss in the same cycle: both take effect (score increments and the miss is processed).
REQ-022 PLAY, pause_btn rising edge: the FSM moves to PAUSE; score, lives and timer are held.
REQ-023 PAUSE: a pause_btn rising edge returns the FSM to PLAY; hit, miss and btn are ignored.
REQ-024 pause_btn rising edges outside PLAY and PAUSE SHALL be ignored; the edge detector uses a 1-cycle registered history.
REQ-025 NEWBALL: the FSM moves to PLAY when the timer is 0 and btn!=0; btn pressed before expiry is ignored.
REQ-026 OVER: the FSM moves to NEWGAME when the timer reaches 0.
REQ-027 On OVER entry, if score>hiscore, hiscore SHALL load score in the same cycle as the transition.
REQ-028 The timer SHALL be 10 bits and decrement once per frame_tick while nonzero; it holds at 0 and never underflows.
REQ-029 A frame_tick coincident with the timer load SHALL be ignored, so the wait is exactly WAIT_FRAMES ticks.
REQ-030 hit and miss SHALL be ignored in every state other than PLAY.

Reset
REQ-031 reset SHALL force state=NEWGAME, lives=LIVES, score=0, hiscore=0, timer=0 and pause history=0; it overrides every other input and aborts any wait or pause.

Structure
REQ-032 A shared package SHALL hold the state encoding constants and the parameter defaults.
REQ-033 The score SHALL be built from one sub-module, bcd_counter (parameter DIGITS; inputs clr, inc; saturating), instantiated once.

Verification
REQ-034 Reset, btn=01, 5 hits: state 0->1, score=05, lives=3, gra_still=0.
REQ-035 LIVES=3, 3 misses with btn held after each wait: NEWBALL for exactly 120 frame_ticks each time; 3rd miss -> OVER, lives=0, hiscore=score; after 120 ticks -> NEWGAME.
REQ-036 Score=98, 3 hits: score 99 and holds at 99.
REQ-037 PLAY, pause_btn rising edge, then hit and miss, then a second rising edge: PAUSE, score and lives unchanged, back to PLAY.
REQ-038 Hit and miss in the same cycle with lives=2: score+1, lives=1, NEWBALL.
REQ-039 reset asserted mid-NEWBALL: next cycle NEWGAME, hiscore=00.
